multicycle_control: RTL and testbench

Main control FSM for the multicycle RISC-V datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath mux select and write strobe, and produces the ALUOp0/ALUOp1 pair consumed by ALU_Control. It stalls on a memory ready handshake and locks up on an illegal opcode.

---
 rtl/multicycle_control_pkg.sv | 48 ++++
 rtl/multicycle_control_main_decoder.sv | 36 +++
 rtl/multicycle_control.sv | 150 +++++++++++++++
 tb/tb_multicycle_control.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared types and encodings for the multicycle control FSM
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] RS_ALUOUT = 2'b00;
    localparam logic [1:0] RS_READ   = 2'b01;
    localparam logic [1:0] RS_ALURES = 2'b10;

    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_OLDPC = 2'b01;
    localparam logic [1:0] SA_RS1   = 2'b10;

    localparam logic [1:0] SB_RS2  = 2'b00;
    localparam logic [1:0] SB_IMM  = 2'b01;
    localparam logic [1:0] SB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALUOp pair packed as {ALUOp1, ALUOp0}
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;

endpackage

// File: rtl/multicycle_control_main_decoder.sv
// rtl/multicycle_control_main_decoder.sv - opcode to immediate format and opcode class flags
module main_decoder
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] imm_src,
    output logic       is_r,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_addi,
    output logic       is_jal,
    output logic       is_illegal
);

    always_comb begin
        imm_src    = IMM_I;
        is_r       = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_addi    = 1'b0;
        is_jal     = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_R:    is_r = 1'b1;
            OP_LW:   is_load = 1'b1;
            OP_SW:   begin is_store = 1'b1;  imm_src = IMM_S; end
            OP_BEQ:  begin is_branch = 1'b1; imm_src = IMM_B; end
            OP_ADDI: is_addi = 1'b1;
            OP_JAL:  begin is_jal = 1'b1;    imm_src = IMM_J; end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       ALUOp0,
    output logic       ALUOp1,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state, next;
    logic       is_r, is_load, is_store, is_branch, is_addi, is_jal, is_illegal;
    logic       pc_update, branch;
    logic       ir_w, mem_w, reg_w, done_w;
    logic [1:0] alu_op;

    main_decoder u_main_decoder (
        .opcode     (opcode),
        .imm_src    (imm_src),
        .is_r       (is_r),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_branch  (is_branch),
        .is_addi    (is_addi),
        .is_jal     (is_jal),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next;
    end

    always_comb begin
        next       = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        done_w     = 1'b0;
        adr_src    = 1'b0;
        result_src = RS_ALUOUT;
        alu_src_a  = SA_PC;
        alu_src_b  = SB_RS2;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SB_FOUR;
                result_src = RS_ALURES;
                if (mem_ready) begin
                    ir_w      = 1'b1;
                    pc_update = 1'b1;
                    next      = S_DECODE;
                end
            end
            S_DECODE: begin
                // target = OldPC + imm, consumed by BEQ/JAL via ALUOut
                alu_src_a = SA_OLDPC;
                alu_src_b = SB_IMM;
                if (is_illegal)              next = S_ILLEGAL;
                else if (is_load | is_store) next = S_MEMADR;
                else if (is_r)               next = S_EXECR;
                else if (is_addi)            next = S_EXECI;
                else if (is_branch)          next = S_BEQ;
                else if (is_jal)             next = S_JAL;
                else                         next = S_ILLEGAL;
            end
            S_MEMADR: begin
                alu_src_a = SA_RS1;
                alu_src_b = SB_IMM;
                next      = is_load ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RS_READ;
                reg_w      = 1'b1;
                done_w     = 1'b1;
                next       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (mem_ready) begin
                    done_w = 1'b1;
                    next   = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = SA_RS1;
                alu_op    = ALUOP_RTYPE;
                next      = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SA_RS1;
                alu_src_b = SB_IMM;
                next      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w  = 1'b1;
                done_w = 1'b1;
                next   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = SA_RS1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                done_w    = 1'b1;
                next      = S_FETCH;
            end
            S_JAL: begin
                // PC <= ALUOut (target) while the ALU forms OldPC + 4 for rd
                alu_src_a = SA_OLDPC;
                alu_src_b = SB_FOUR;
                pc_update = 1'b1;
                next      = S_ALUWB;
            end
            S_ILLEGAL: next = S_ILLEGAL;
            default:   next = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing fires during the async reset window
    assign pc_write   = ~reset & (pc_update | (branch & zero));
    assign ir_write   = ~reset & ir_w;
    assign mem_write  = ~reset & mem_w;
    assign reg_write  = ~reset & reg_w;
    assign instr_done = ~reset & done_w;
    assign ALUOp0     = alu_op[0];
    assign ALUOp1     = alu_op[1];
    assign illegal    = (state == S_ILLEGAL);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench with directed per-cycle expected vectors
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'b0110011;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic       ALUOp0, ALUOp1, instr_done, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];
    string       name_q[$];
    logic [17:0] act;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .ALUOp0     (ALUOp0),
        .ALUOp1     (ALUOp1),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, imm_src, reg_write, ALUOp0, ALUOp1, instr_done, illegal};

    // Field order: pcw adr mw irw rs sa sb imm rw op0 op1 done ill
    function automatic logic [17:0] e(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] imm, input logic rw,
                                      input logic a0, input logic a1, input logic dn, input logic il);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, a0, a1, dn, il};
    endfunction

    function automatic logic [17:0] fe(input logic [1:0] imm, input logic rdy);
        return e(rdy, 0, 0, rdy, 2'b10, 2'b00, 2'b10, imm, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] de(input logic [1:0] imm);
        return e(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] rv(input logic [1:0] imm);
        return e(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] wb(input logic [1:0] imm);
        return e(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 1, 0, 0, 1, 0);
    endfunction

    task automatic step(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                        input logic [17:0] ev, input string nm);
        @(posedge clk);
        #1;
        reset     = r;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        exp_q.push_back(ev);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [17:0] ev;
            string       nm;
            ev = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (act !== ev) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", nm, act, ev);
            end
        end
    end

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] AI  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    initial begin
        step(1, R, 0, 1, rv(2'b00), "reset0");
        step(1, R, 0, 1, rv(2'b00), "reset1");

        step(0, R, 0, 1, fe(2'b00, 1), "r.fetch");
        step(0, R, 0, 1, de(2'b00), "r.decode");
        step(0, R, 0, 1, e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,1,0,0,0), "r.execr");
        step(0, R, 0, 1, wb(2'b00), "r.aluwb");

        step(0, LW, 0, 0, fe(2'b00, 0), "lw.fetch_wait0");
        step(0, LW, 0, 0, fe(2'b00, 0), "lw.fetch_wait1");
        step(0, LW, 0, 1, fe(2'b00, 1), "lw.fetch");
        step(0, LW, 0, 1, de(2'b00), "lw.decode");
        step(0, LW, 0, 0, e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0,0,0), "lw.memadr");
        for (int i = 0; i < 3; i++)
            step(0, LW, 0, 0, e(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0), "lw.memread_wait");
        step(0, LW, 0, 1, e(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0), "lw.memread");
        step(0, LW, 0, 1, e(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,0,0,1,0), "lw.memwb");

        step(0, SW, 0, 1, fe(2'b01, 1), "sw.fetch");
        step(0, SW, 0, 0, de(2'b01), "sw.decode");
        step(0, SW, 0, 0, e(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,0,0,0,0), "sw.memadr");
        step(0, SW, 0, 0, e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,0,0,0,0), "sw.memwrite_wait0");
        step(0, SW, 0, 0, e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,0,0,0,0), "sw.memwrite_wait1");
        step(0, SW, 0, 1, e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,0,0,1,0), "sw.memwrite_exit");

        step(0, BQ, 1, 1, fe(2'b10, 1), "beq1.fetch");
        step(0, BQ, 1, 1, de(2'b10), "beq1.decode");
        step(0, BQ, 1, 1, e(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,1,1,0), "beq1.taken");
        step(0, BQ, 0, 1, fe(2'b10, 1), "beq0.fetch");
        step(0, BQ, 0, 1, de(2'b10), "beq0.decode");
        step(0, BQ, 0, 1, e(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,1,1,0), "beq0.not_taken");

        step(0, AI, 0, 1, fe(2'b00, 1), "addi.fetch");
        step(0, AI, 0, 1, de(2'b00), "addi.decode");
        step(0, AI, 0, 1, e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0,0,0), "addi.execi");
        step(0, AI, 0, 1, wb(2'b00), "addi.aluwb");

        step(0, JL, 0, 1, fe(2'b11, 1), "jal.fetch");
        step(0, JL, 0, 1, de(2'b11), "jal.decode");
        step(0, JL, 0, 1, e(1,0,0,0,2'b00,2'b01,2'b10,2'b11,0,0,0,0,0), "jal.jal");
        step(0, JL, 0, 1, wb(2'b11), "jal.aluwb");

        step(0, BAD, 0, 1, fe(2'b00, 1), "bad.fetch");
        step(0, BAD, 1, 1, de(2'b00), "bad.decode");
        for (int i = 0; i < 20; i++)
            step(0, BAD, 1, i[0], e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0,1), "bad.locked");
        step(1, BAD, 1, 1, rv(2'b00), "bad.async_reset");
        step(0, R, 0, 1, fe(2'b00, 1), "restart.fetch");
        step(0, R, 0, 1, de(2'b00), "restart.decode");
        step(0, R, 0, 1, e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,1,0,0,0), "restart.execr");
        step(0, R, 0, 1, wb(2'b00), "restart.aluwb");

        step(0, SW, 0, 1, fe(2'b01, 1), "abort.fetch");
        step(0, SW, 0, 1, de(2'b01), "abort.decode");
        step(0, SW, 0, 1, e(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,0,0,0,0), "abort.memadr");
        step(1, SW, 0, 1, rv(2'b01), "abort.reset_in_memwrite");
        step(0, SW, 0, 1, fe(2'b01, 1), "abort.refetch");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
